// File: rtl/load_store_unit.sv
// Load/store initiator: takes one pipeline request at a time, performs word-wide
// memory accesses (read-modify-write for sub-word stores) and returns an extended result.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddress,
  input  logic [31:0] ReqWriteData,
  output logic        RespValid,
  output logic [31:0] RespReadData,
  output logic        RespError,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemReadData,
  input  logic        MemAck,
  output logic [2:0]  DebugState
);

  // Handshake: a request transfers on the rising edge where ReqValid && ReqReady;
  // ReqReady is high only in IDLE. Responses are a single-cycle RespValid pulse with
  // no back-pressure. Mem* requests are held until the cycle in which MemAck is high.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } lsuStateT;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  lsuStateT    state, stateNext;
  logic [7:0]  waitCount, waitCountNext;
  logic [1:0]  laneQ, laneNext;
  logic [1:0]  sizeQ, sizeNext;
  logic        signedQ, signedNext;
  logic [31:0] dataQ, dataNext;
  logic        memReadNext, memWriteNext;
  logic [31:0] memAddressNext, memWriteDataNext;
  logic        respValidNext, respErrorNext;
  logic [31:0] respReadDataNext;
  logic        reqError;

  assign ReqReady   = (state == IDLE);
  assign DebugState = state;

  function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] mergeStore(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic [31:0] data);
    logic [31:0] merged;
    merged = word;
    if (size == 2'b00) merged[{lane, 3'b000} +: 8] = data[7:0];
    else               merged[{lane[1], 4'b0000} +: 16] = data[15:0];
    return merged;
  endfunction

  assign reqError = (ReqSize == 2'b11) ||
                    (ReqSize == 2'b01 && ReqAddress[0]) ||
                    (ReqSize == 2'b10 && ReqAddress[1:0] != 2'b00);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state        <= IDLE;
      waitCount    <= 8'd0;
      laneQ        <= 2'b00;
      sizeQ        <= 2'b00;
      signedQ      <= 1'b0;
      dataQ        <= 32'd0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemAddress   <= 32'd0;
      MemWriteData <= 32'd0;
      RespValid    <= 1'b0;
      RespError    <= 1'b0;
      RespReadData <= 32'd0;
    end else begin
      state        <= stateNext;
      waitCount    <= waitCountNext;
      laneQ        <= laneNext;
      sizeQ        <= sizeNext;
      signedQ      <= signedNext;
      dataQ        <= dataNext;
      MemRead      <= memReadNext;
      MemWrite     <= memWriteNext;
      MemAddress   <= memAddressNext;
      MemWriteData <= memWriteDataNext;
      RespValid    <= respValidNext;
      RespError    <= respErrorNext;
      RespReadData <= respReadDataNext;
    end
  end

  always_comb begin
    stateNext        = state;
    waitCountNext    = waitCount;
    laneNext         = laneQ;
    sizeNext         = sizeQ;
    signedNext       = signedQ;
    dataNext         = dataQ;
    memReadNext      = MemRead;
    memWriteNext     = MemWrite;
    memAddressNext   = MemAddress;
    memWriteDataNext = MemWriteData;
    respValidNext    = 1'b0;
    respErrorNext    = 1'b0;
    respReadDataNext = 32'd0;

    case (state)
      IDLE: begin
        if (ReqValid) begin
          laneNext   = ReqAddress[1:0];
          sizeNext   = ReqSize;
          signedNext = ReqSigned;
          dataNext   = ReqWriteData;
          if (reqError) begin
            stateNext     = RESP;
            respValidNext = 1'b1;
            respErrorNext = 1'b1;
          end else begin
            memAddressNext = {2'b00, ReqAddress[31:2]};
            waitCountNext  = 8'd0;
            if (!ReqWrite) begin
              stateNext   = READ;
              memReadNext = 1'b1;
            end else if (ReqSize == 2'b10) begin
              stateNext        = WRITE;
              memWriteNext     = 1'b1;
              memWriteDataNext = ReqWriteData;
            end else begin
              stateNext   = RMW_READ;
              memReadNext = 1'b1;
            end
          end
        end
      end
      READ: begin
        if (MemAck) begin
          stateNext        = RESP;
          memReadNext      = 1'b0;
          respValidNext    = 1'b1;
          respReadDataNext = extractLoad(MemReadData, laneQ, sizeQ, signedQ);
        end else if (waitCount == TimeoutLast) begin
          stateNext     = RESP;
          memReadNext   = 1'b0;
          respValidNext = 1'b1;
          respErrorNext = 1'b1;
        end else begin
          waitCountNext = waitCount + 8'd1;
        end
      end
      RMW_READ: begin
        // A timed-out read abandons the store: no write is issued.
        if (MemAck) begin
          stateNext        = WRITE;
          memReadNext      = 1'b0;
          memWriteNext     = 1'b1;
          memWriteDataNext = mergeStore(MemReadData, laneQ, sizeQ, dataQ);
          waitCountNext    = 8'd0;
        end else if (waitCount == TimeoutLast) begin
          stateNext     = RESP;
          memReadNext   = 1'b0;
          respValidNext = 1'b1;
          respErrorNext = 1'b1;
        end else begin
          waitCountNext = waitCount + 8'd1;
        end
      end
      WRITE: begin
        if (MemAck) begin
          stateNext     = RESP;
          memWriteNext  = 1'b0;
          respValidNext = 1'b1;
        end else if (waitCount == TimeoutLast) begin
          stateNext     = RESP;
          memWriteNext  = 1'b0;
          respValidNext = 1'b1;
          respErrorNext = 1'b1;
        end else begin
          waitCountNext = waitCount + 8'd1;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext    = IDLE;
        memReadNext  = 1'b0;
        memWriteNext = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a wait-state memory responder, a request
// driver task and an expected-response queue, with TIMEOUT set to 4.
module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAddress, ReqWriteData;
  logic        RespValid, RespError;
  logic [31:0] RespReadData;
  logic [31:0] MemAddress, MemWriteData, MemReadData;
  logic        MemRead, MemWrite, MemAck;
  logic [2:0]  DebugState;

  load_store_unit #(.TIMEOUT(4)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
    .ReqSigned(ReqSigned), .ReqAddress(ReqAddress), .ReqWriteData(ReqWriteData),
    .RespValid(RespValid), .RespReadData(RespReadData), .RespError(RespError),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemReadData(MemReadData), .MemAck(MemAck),
    .DebugState(DebugState)
  );

  always #5 Clock = ~Clock;

  int checkCount = 0;
  int failCount  = 0;
  logic [31:0] expQ[$];

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after waitCycles idle cycles of a held request.
  logic [31:0] memModel [0:63];
  bit ackOn = 1'b1;
  int waitCycles = 0;
  int waitCnt = 0;

  always @(negedge Clock) begin
    MemAck = 1'b0;
    if ((MemRead || MemWrite) && ackOn) begin
      if (waitCnt == waitCycles) begin
        MemAck      = 1'b1;
        MemReadData = memModel[MemAddress[5:0]];
        if (MemWrite) memModel[MemAddress[5:0]] = MemWriteData;
        waitCnt = 0;
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
    end
  end

  int          respCycle, readCycles, writeCycles;
  logic [31:0] respData, wdSeen;
  logic        respErr, overlapSeen, addrBad, readyBad;

  // Called just after a falling edge; the request is accepted on the next rising edge (cycle 0).
  task automatic runReq(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expAddr, input string tag);
    logic [31:0] expData;
    respCycle = 0; readCycles = 0; writeCycles = 0; respData = '0; respErr = 1'b0;
    wdSeen = '0; overlapSeen = 1'b0; addrBad = 1'b0;
    readyBad = !ReqReady;
    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg;
    ReqAddress = addr; ReqWriteData = wdata;
    for (int n = 1; n <= 40 && respCycle == 0; n++) begin
      @(negedge Clock); #1;
      ReqValid = 1'b0;
      if (MemRead) readCycles++;
      if (MemWrite) writeCycles++;
      if (MemRead && MemWrite) overlapSeen = 1'b1;
      if ((MemRead || MemWrite) && MemAddress != expAddr) addrBad = 1'b1;
      if (MemWrite && MemAck) wdSeen = MemWriteData;
      if (ReqReady) readyBad = 1'b1;
      if (RespValid) begin
        respCycle = n; respData = RespReadData; respErr = RespError;
      end
    end
    expData = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
    checkValue({tag, "_data"}, respData, expData);
    @(negedge Clock); #1;
    checkValue({tag, "_pulse"}, {31'd0, RespValid}, 32'd0);
    checkValue({tag, "_ready_after"}, {31'd0, ReqReady}, 32'd1);
  endtask

  initial begin
    ResetN = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqSigned = 1'b0;
    ReqAddress = '0; ReqWriteData = '0; MemReadData = '0; MemAck = 1'b0;
    for (int i = 0; i < 64; i++) memModel[i] = 32'h0;
    memModel[4] = 32'h80FF_7F01;
    memModel[8] = 32'h1234_5678;
    memModel[9] = 32'h1122_3344;
    repeat (3) @(negedge Clock);
    #1;
    checkValue("rst_ready", {31'd0, ReqReady}, 32'd1);
    checkValue("rst_resp", {30'd0, RespValid, RespError}, 32'd0);
    checkValue("rst_mem", {30'd0, MemRead, MemWrite}, 32'd0);
    checkValue("rst_addr", MemAddress, 32'd0);
    checkValue("rst_wdata", MemWriteData, 32'd0);
    checkValue("rst_rdata", RespReadData, 32'd0);
    ResetN = 1'b1;
    @(negedge Clock); #1;

    // Byte loads, lane 3, zero-wait
    waitCycles = 0;
    expQ.push_back(32'hFFFF_FF80);
    runReq(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'd4, "lb_signed");
    checkValue("lb_signed_cycle", respCycle, 32'd2);
    checkValue("lb_signed_err", {31'd0, respErr}, 32'd0);
    checkValue("lb_signed_addr", {31'd0, addrBad}, 32'd0);
    checkValue("lb_signed_reads", readCycles, 32'd1);
    expQ.push_back(32'h0000_0080);
    runReq(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'd4, "lb_unsigned");
    checkValue("lb_unsigned_cycle", respCycle, 32'd2);

    // Signed halfword load, upper half, one wait cycle
    waitCycles = 1;
    expQ.push_back(32'hFFFF_80FF);
    runReq(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'd4, "lh_signed");
    checkValue("lh_signed_cycle", respCycle, 32'd3);

    // Halfword RMW store, 3 wait cycles: ack lands as the watchdog reaches TIMEOUT
    waitCycles = 3;
    expQ.push_back(32'h0);
    runReq(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 32'd8, "sh_rmw");
    checkValue("sh_rmw_wdata", wdSeen, 32'hBEEF_5678);
    checkValue("sh_rmw_mem", memModel[8], 32'hBEEF_5678);
    checkValue("sh_rmw_addr", {31'd0, addrBad}, 32'd0);
    checkValue("sh_rmw_overlap", {31'd0, overlapSeen}, 32'd0);
    checkValue("sh_rmw_cycle", respCycle, 32'd9);
    checkValue("sh_rmw_counts", {readCycles[15:0], writeCycles[15:0]}, {16'd4, 16'd4});
    checkValue("sh_rmw_err", {31'd0, respErr}, 32'd0);

    // Byte RMW store lane 1, zero-wait: 3-cycle latency
    waitCycles = 0;
    expQ.push_back(32'h0);
    runReq(1'b1, 2'b00, 1'b0, 32'h25, 32'hFFFF_FFA5, 32'd9, "sb_rmw");
    checkValue("sb_rmw_mem", memModel[9], 32'h1122_A544);
    checkValue("sb_rmw_cycle", respCycle, 32'd3);

    // Request errors: no memory access, response in cycle 1
    expQ.push_back(32'h0);
    runReq(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'd0, "lw_misalign");
    checkValue("lw_misalign_cycle", respCycle, 32'd1);
    checkValue("lw_misalign_err", {31'd0, respErr}, 32'd1);
    checkValue("lw_misalign_mem", {readCycles[15:0], writeCycles[15:0]}, 32'd0);
    expQ.push_back(32'h0);
    runReq(1'b1, 2'b01, 1'b0, 32'h1, 32'h1234, 32'd0, "sh_misalign");
    checkValue("sh_misalign_err", {31'd0, respErr}, 32'd1);
    checkValue("sh_misalign_mem", {readCycles[15:0], writeCycles[15:0]}, 32'd0);
    expQ.push_back(32'h0);
    runReq(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'd0, "illegal_size");
    checkValue("illegal_size_err", {31'd0, respErr}, 32'd1);
    checkValue("illegal_size_cycle", respCycle, 32'd1);

    // Load timeout, then a normal load accepted right after
    ackOn = 1'b0;
    expQ.push_back(32'h0);
    runReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'd4, "lw_timeout");
    checkValue("lw_timeout_reads", readCycles, 32'd4);
    checkValue("lw_timeout_cycle", respCycle, 32'd5);
    checkValue("lw_timeout_err", {31'd0, respErr}, 32'd1);
    ackOn = 1'b1;
    expQ.push_back(32'h80FF_7F01);
    runReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'd4, "lw_after_timeout");
    checkValue("lw_after_timeout_err", {31'd0, respErr}, 32'd0);

    // RMW read timeout skips the write
    ackOn = 1'b0;
    expQ.push_back(32'h0);
    runReq(1'b1, 2'b00, 1'b0, 32'h24, 32'h0000_0077, 32'd9, "sb_timeout");
    checkValue("sb_timeout_counts", {readCycles[15:0], writeCycles[15:0]}, {16'd4, 16'd0});
    checkValue("sb_timeout_err", {31'd0, respErr}, 32'd1);
    checkValue("sb_timeout_mem", memModel[9], 32'h1122_A544);

    // Reset during a stalled write
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqSigned = 1'b0;
    ReqAddress = 32'h40; ReqWriteData = 32'h5555_AAAA;
    @(negedge Clock); #1;
    ReqValid = 1'b0;
    @(negedge Clock); #1;
    checkValue("rst_mid_write_before", {31'd0, MemWrite}, 32'd1);
    ResetN = 1'b0;
    #1;
    checkValue("rst_mid_write_async", {31'd0, MemWrite}, 32'd0);
    checkValue("rst_mid_ready", {31'd0, ReqReady}, 32'd1);
    @(negedge Clock); #1;
    ResetN = 1'b1;
    respCycle = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge Clock); #1;
      if (RespValid || MemWrite) respCycle = 1;
    end
    checkValue("rst_mid_no_resp", respCycle, 32'd0);
    checkValue("rst_mid_ready_after", {31'd0, ReqReady}, 32'd1);
    ackOn = 1'b1;

    // Back-to-back word store then word load, zero-wait
    waitCycles = 0;
    expQ.push_back(32'h0);
    runReq(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D, 32'd12, "b2b_store");
    checkValue("b2b_store_cycle", respCycle, 32'd2);
    checkValue("b2b_store_ready", {31'd0, readyBad}, 32'd0);
    expQ.push_back(32'hCAFE_F00D);
    runReq(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'd12, "b2b_load");
    checkValue("b2b_load_cycle", respCycle, 32'd2);
    checkValue("b2b_load_ready", {31'd0, readyBad}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface. Accepts one load or store at a time from the CPU pipeline through a valid/ready handshake, splits it into word-wide memory accesses (MemRead/MemWrite, word address, 32-bit data), and returns an extracted or extended result.
- Byte and halfword stores are done as read-modify-write, because the data memory is word-only.
- A watchdog converts a memory access that never completes into an error response.

## Interface
- TIMEOUT, 255, maximum cycles to wait for MemAck per memory access (1..255).
- Clock  in  1  rising-edge clock.
- ResetN  in  1  asynchronous, active-low reset.
- ReqValid  in  1  pipeline presents a request.
- ReqReady  out  1  unit can accept; high only in IDLE.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- ReqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- ReqAddress  in  32  byte address.
- ReqWriteData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- RespValid  out  1  one-cycle completion pulse.
- RespReadData  out  32  load result; 0 for stores and errors.
- RespError  out  1  qualifies RespValid: misaligned, illegal size, or timeout.
- MemAddress  out  32  word address = {2'b00, latched ReqAddress[31:2]}.
- MemWriteData  out  32  word to write.
- MemRead  out  1  read request, held until MemAck.
- MemWrite  out  1  write request, held until MemAck.
- MemReadData  in  32  read data; valid in the MemAck cycle.
- MemAck  in  1  access completes in this cycle. Ignored when neither MemRead nor MemWrite is high.

## Operation
- States: IDLE, READ, RMW_READ, WRITE, RESP.
- IDLE: ReqReady=1.
  - A request is accepted on ReqValid&&ReqReady.
  - On acceptance, address, size, signed flag, write flag and data are latched.
- Alignment check at acceptance:
  - halfword with addr[0]=1 is an error;
  - word with addr[1:0]≠0 is an error;
  - size 11 is an error;
  - any error goes to RESP with RespError=1 and makes no memory access.
- Next state from IDLE: load → READ; word store → WRITE; byte or halfword store → RMW_READ.
- READ: MemRead=1 until MemAck.
  - The MemAck-cycle MemReadData is captured.
  - Lane select is little-endian: byte n is bits [8n+7:8n], n = addr[1:0]; the halfword is at addr[1].
  - The selected lane is sign- or zero-extended per ReqSigned, then the unit goes to RESP.
- RMW_READ: MemRead=1 until MemAck.
  - The captured word is merged with ReqWriteData into the addressed lane; other lanes are unchanged.
  - Then the unit goes to WRITE.
- WRITE: MemWrite=1 and MemWriteData is held stable until MemAck, then the unit goes to RESP.
- RESP: RespValid=1 for exactly one cycle, then IDLE. The response has no back-pressure.
- Watchdog:
  - An 8-bit counter clears on entry to READ, RMW_READ and WRITE and increments each cycle without MemAck.
  - When it reaches TIMEOUT, the unit drops MemRead/MemWrite and goes to RESP with RespError=1 and RespReadData=0.
  - A timeout during RMW_READ skips the write.
- MemAck in the same cycle the counter reaches TIMEOUT counts as success.
- MemRead and MemWrite are never high together.
- MemAddress is constant from acceptance until RESP, including across the RMW_READ→WRITE boundary.

## Timing
- All outputs are registered except ReqReady, which is decoded from state.
- Reset values: state IDLE, ReqReady=1; RespValid, RespError, RespReadData, MemAddress, MemWriteData, MemRead, MemWrite all 0.
- Asserting ResetN mid-access drops MemRead/MemWrite immediately (asynchronously). The request is abandoned and no response is issued.
- Acceptance in cycle 0 puts MemRead or MemWrite high in cycle 1.
- MemAck in cycle k gives:
  - RespValid in k+1 for a load or word store;
  - for a sub-word store, MemRead low and MemWrite high in k+1.
- Zero-wait memory (MemAck in the first request cycle): load or word store latency is 2 cycles; sub-word store is 3.
- Misaligned or illegal request: RespValid in cycle 1, with no Mem* activity.
- Back-to-back throughput: a new request can be accepted in the cycle after RESP.

## Test plan
- Load byte, signed, addr 0x0000_0013:
  - stimulus: mem word 4 = 0x80FF_7F01, MemAck the first cycle;
  - required: MemAddress=4, RespReadData=0xFFFF_FF80 in cycle 2.
  - Repeat with ReqSigned=0: required 0x0000_0080.
- Store halfword 0xBEEF to addr 0x0000_0022, mem word 8 = 0x1234_5678, MemAck after 3 wait cycles:
  - required: MemWriteData=0xBEEF_5678;
  - MemAddress=8 throughout;
  - MemRead and MemWrite never overlap.
- Misaligned word load at addr 0x0000_0006:
  - required: RespValid and RespError in cycle 1, RespReadData=0, MemRead never asserted.
- Timeout with TIMEOUT=4, MemAck never asserted on a load:
  - required: MemRead high for exactly 4 cycles, then RespError=1; the next request is accepted.
- Reset mid-access (ResetN low while MemWrite=1, wait state):
  - required: MemWrite=0 in the same cycle, no RespValid, ReqReady=1 after release.
- Back-to-back word store then word load at the same address with a zero-wait memory model:
  - required: the load returns the stored value;
  - ReqReady is low except in IDLE;
  - each RespValid lasts 1 cycle.
